// File: rtl/mem_copy_dma.sv
// mem_copy_dma: bus initiator that copies a block of words, or fills a block
// with a constant, over the CPU-side memory protocol.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               one-cycle request, honoured only in IDLE
//   fill                0 = copy, 1 = fill (captured with start)
//   src_addr, dst_addr  source / destination base addresses (captured)
//   len                 word count 0..511 (captured)
//   fill_value          word written in fill mode (captured)
//   read_data           data returned by the address decoder
//   mem_cmd             00 none, 10 read, 11 write
//   mem_addr            bus address
//   write_data          write data, meaningful only while mem_cmd = 11
//   busy                high in RD, WAIT and WR
//   done                one-cycle pulse in DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus quiet, waiting for start
// RD    | read command presented at src+i
// WAIT  | read held at src+i, read_data latched at end of cycle
// WR    | write dst+i, advance i, decide next word or finish
// DONE  | done pulse, bus quiet, back to IDLE
module mem_copy_dma #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fill,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] read_data,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              fill_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] len_q;
    logic [DATA_W-1:0] fill_value_q;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_next;
    logic              last_word;

    always_comb begin
        idx_next  = idx + ONE;
        last_word = (idx_next == len_q);
    end

    // Outputs are registered and loaded on the edge that enters each state,
    // so every bus value belongs to the cycle of the state it describes.
    // In copy mode write_data doubles as the read buffer: it is loaded from
    // read_data on the edge that ends WAIT and presented during WR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            fill_q       <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            fill_value_q <= '0;
            idx          <= '0;
            mem_cmd      <= CMD_NONE;
            mem_addr     <= '0;
            write_data   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_cmd    <= CMD_NONE;
                    mem_addr   <= '0;
                    write_data <= '0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    if (start) begin
                        fill_q       <= fill;
                        src_q        <= src_addr;
                        dst_q        <= dst_addr;
                        len_q        <= len;
                        fill_value_q <= fill_value;
                        idx          <= '0;
                        if (len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (fill) begin
                            state      <= S_WR;
                            mem_cmd    <= CMD_WRITE;
                            mem_addr   <= dst_addr;
                            write_data <= fill_value;
                            busy       <= 1'b1;
                        end else begin
                            state    <= S_RD;
                            mem_cmd  <= CMD_READ;
                            mem_addr <= src_addr;
                            busy     <= 1'b1;
                        end
                    end
                end

                // Command and address stay put: the decoder qualifies
                // read_data with them during WAIT.
                S_RD: begin
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    state      <= S_WR;
                    mem_cmd    <= CMD_WRITE;
                    mem_addr   <= dst_q + idx;
                    write_data <= read_data;
                end

                S_WR: begin
                    idx <= idx_next;
                    if (last_word) begin
                        state      <= S_DONE;
                        mem_cmd    <= CMD_NONE;
                        mem_addr   <= '0;
                        write_data <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else if (fill_q) begin
                        state      <= S_WR;
                        mem_addr   <= dst_q + idx_next;
                        write_data <= fill_value_q;
                    end else begin
                        state      <= S_RD;
                        mem_cmd    <= CMD_READ;
                        mem_addr   <= src_q + idx_next;
                        write_data <= '0;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state      <= S_IDLE;
                    mem_cmd    <= CMD_NONE;
                    mem_addr   <= '0;
                    write_data <= '0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule
